// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store stage with an internal multi-cycle, byte-addressable,
// little-endian data memory. One request per instruction. A combinational stall holds
// the CPU until the access completes.
//
// Build option: define LSU_MISALIGN_CHECK_EN to flag misaligned or reserved-size requests.
// Without it, size 11 is treated as word, low address bits are forced to zero, every
// request goes through BUSY, and misalign_o stays 0.
module lsu_mem_stage #(
    parameter int unsigned MEM_WORDS = 128,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            wr_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;

    logic [31:0]     mem_q [MEM_WORDS];

    logic [1:0]      eff_size;
    logic [AW+1:0]   eff_addr;
    logic            bad;

    logic [31:0]     cur_word;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic [31:0]     load_val;
    logic [31:0]     store_val;
    logic            access;

    // Upper address bits only select an alias of the same word, so they are dropped.
    logic            unused_addr;
    assign unused_addr = ^addr_i[31:AW+2];

    // Classify and normalise the incoming request before capture.
    always_comb begin
        eff_size = req_size_i;
        eff_addr = addr_i[AW+1:0];
        bad      = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        unique case (req_size_i)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_i[0];
            2'b10:   bad = |addr_i[1:0];
            default: bad = 1'b1;
        endcase
`else
        if (req_size_i == 2'b11) begin
            eff_size = 2'b10;
        end
        if (eff_size == 2'b01) begin
            eff_addr[0] = 1'b0;
        end else if (eff_size == 2'b10) begin
            eff_addr[1:0] = 2'b00;
        end
`endif
    end

    // Lane selection and extension for loads; lane merge for stores.
    always_comb begin
        cur_word  = mem_q[addr_q[AW+1:2]];
        lane_byte = cur_word[{addr_q[1:0], 3'b000} +: 8];
        lane_half = cur_word[{addr_q[1], 4'b0000} +: 16];
        load_val  = cur_word;
        store_val = cur_word;
        unique case (size_q)
            2'b00: begin
                load_val = uns_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
                store_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_val = uns_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
                store_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_val  = cur_word;
                store_val = wdata_q;
            end
        endcase
    end

    // The access happens in the last BUSY cycle.
    assign access  = (state_q == StBusy) && (cnt_q == '0);
    assign stall_o = ((state_q == StIdle) && req_valid_i) || (state_q == StBusy);

    // Request FSM with registered done/misalign/rdata outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            rdata_o    <= '0;
        end else begin
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        wr_q    <= req_write_i;
                        size_q  <= eff_size;
                        uns_q   <= req_unsigned_i;
                        addr_q  <= eff_addr;
                        wdata_q <= wdata_i;
                        cnt_q   <= CW'(LATENCY - 1);
                        if (bad) begin
                            state_q    <= StDone;
                            done_o     <= 1'b1;
                            misalign_o <= 1'b1;
                            rdata_o    <= '0;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                        done_o  <= 1'b1;
                        if (!wr_q) begin
                            rdata_o <= load_val;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                // The CPU still presents the completed instruction here; ignore it.
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Data array; reset clears it and wins over a store completing on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (access && wr_q) begin
            mem_q[addr_q[AW+1:2]] <= store_val;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed test-plan steps followed by random traffic, all
// checked against a byte-array model of the memory.
module tb_lsu_mem_stage;

    localparam int unsigned MEM_WORDS = 128;
    localparam int unsigned LATENCY   = 2;
    localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;

    int total = 0;
    int bad = 0;

    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] ref_rd = '0;
    logic [31:0] got_rd;
    logic        got_mis;

    lsu_mem_stage #(
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_write_i    (req_write),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .stall_o        (stall),
        .done_o         (done),
        .rdata_o        (rdata),
        .misalign_o     (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;
        ref_rd = '0;
    endfunction

    // Reference behaviour from the byte-level rules: returns expected rdata and misalign.
    function automatic void model_access(input logic wr, input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic mis);
        logic [1:0]  s;
        logic [31:0] aa;
        logic [31:0] v;
        int unsigned nbytes;
        int unsigned base;
        s   = sz;
        aa  = a;
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) mis = 1'b1;
`else
        if (s == 2'b11) s = 2'b10;
        if (s == 2'b01) aa[0] = 1'b0;
        if (s == 2'b10) aa[1:0] = 2'b00;
`endif
        if (mis) begin
            ref_rd = '0;
            rd = ref_rd;
            return;
        end
        nbytes = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        base = aa % MEM_BYTES;
        if (wr) begin
            for (int i = 0; i < int'(nbytes); i++) ref_mem[(base + i) % MEM_BYTES] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < int'(nbytes); i++) v[8*i +: 8] = ref_mem[(base + i) % MEM_BYTES];
            if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
            ref_rd = v;
        end
        rd = ref_rd;
    endfunction

    // Issue one request, follow its handshake and compare against the model.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] exp_rd;
        logic        exp_mis;
        int          exp_lat;
        int          k;
        logic        seen;
        model_access(wr, sz, uns, a, wd, exp_rd, exp_mis);
        exp_lat = exp_mis ? 1 : int'(LATENCY) + 1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        addr = a; wdata = wd;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                check({tag, "_stall"}, 32'(stall), 32'd1);
                k++;
            end
        end
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        check({tag, "_rdata"}, rdata, exp_rd);
        check({tag, "_misalign"}, 32'(misalign), 32'(exp_mis));
        got_rd = rdata;
        got_mis = misalign;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Scramble inputs to show they are not sampled outside capture.
        wdata = $urandom; addr = $urandom;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_misalign", 32'(misalign), 32'd0);
        rst = 1'b0;

        // Word store then load.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "sw10");
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw10");
        check("tp_lw10", got_rd, 32'hDEADBEEF);

        // Byte store into a cleared word.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, "sw10_zero");
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h7F, "sb11");
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, "lbu11");
        check("tp_lbu11", got_rd, 32'h0000007F);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw10b");
        check("tp_lw10b", got_rd, 32'h00007F00);

        // Halfword signed / unsigned.
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h8001, "sh22");
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, "lh22");
        check("tp_lh22", got_rd, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, "lhu22");
        check("tp_lhu22", got_rd, 32'h00008001);

        // Misaligned word load.
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, "lw13");
`ifdef LSU_MISALIGN_CHECK_EN
        check("tp_lw13", got_rd, 32'h0);
        check("tp_lw13_mis", 32'(got_mis), 32'd1);
`else
        check("tp_lw13", got_rd, 32'h00007F00);
`endif
        // Store must leave rdata unchanged.
        do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, "sw30_hold");

        // Reset while the store is in its final BUSY cycle.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        addr = 32'h04; wdata = 32'h12345678;
        repeat (int'(LATENCY) + 1) @(negedge clk);
        check("rstbusy_stall_before", 32'(stall), 32'd1);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstbusy_stall", 32'(stall), 32'd0);
        check("rstbusy_done", 32'(done), 32'd0);
        check("rstbusy_rdata", rdata, 32'd0);
        rst = 1'b0;
        model_reset();
        do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, "lw04_after_rst");
        check("tp_lw04", got_rd, 32'h0);

        // Address wrap.
        do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'hA5A5A5A5, "sw200");
        do_req(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, "lw000");
        check("tp_wrap", got_rd, 32'hA5A5A5A5);

        // Random traffic over a small window plus aliases.
        for (int n = 0; n < 80; n++) begin
            wr  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 7)) << 9);
            do_req(wr, sz, uns, a, $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
